// File: rtl/memc_req.sv
// memc_req: initiator side of the 64k x 8 memory-controller request port.
// Splits a CPU byte/word access into one or two single-byte controller
// transactions, follows the controller busy handshake, assembles 16-bit
// little-endian read data and raises a sticky error on handshake timeout.
//
// Ports
//   clk, reset        clock (rising edge), synchronous active-low reset
//   cpu_req/we/word   CPU request: valid, write, 16-bit access
//   cpu_addr/wdata    CPU byte address, write data ([7:0] -> addr, [15:8] -> addr+1)
//   cpu_ack/rdata     one-cycle completion pulse, read result (held until next ack)
//   cpu_err           sticky fault flag
//   ready             high only while idle
//   mem_addr/wdata    controller address and write byte
//   mem_read_en/write_en  one-cycle controller commands
//   mem_busy/rdata    controller busy and read byte
//
// state    | meaning
// INIT     | waiting for controller self-test (busy low)
// IDLE     | accepting a CPU request
// ISSUE_LO | command for the low byte is on the bus
// WAIT_LO  | waiting for low-byte transaction to complete
// ISSUE_HI | command for the high byte (addr+1) is on the bus
// WAIT_HI  | waiting for high-byte transaction to complete
// DONE     | cpu_ack pulse
// FAULT    | handshake timeout, left only by reset
module memc_req #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_word,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        cpu_err,
  output logic        ready,
  output logic [15:0] mem_addr,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [7:0]  mem_wdata,
  input  logic        mem_busy,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [7:0] {
    S_INIT     = 8'b0000_0001,
    S_IDLE     = 8'b0000_0010,
    S_ISSUE_LO = 8'b0000_0100,
    S_WAIT_LO  = 8'b0000_1000,
    S_ISSUE_HI = 8'b0001_0000,
    S_WAIT_HI  = 8'b0010_0000,
    S_DONE     = 8'b0100_0000,
    S_FAULT    = 8'b1000_0000
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             seen_busy_q;
  logic [15:0]      addr_q;
  logic             we_q;
  logic             word_q;
  logic [15:0]      wdata_q;
  logic [7:0]       rlo_q;

  logic             cpu_ack_q;
  logic [15:0]      cpu_rdata_q;
  logic             cpu_err_q;
  logic             ready_q;
  logic [15:0]      mem_addr_q;
  logic             mem_read_en_q;
  logic             mem_write_en_q;
  logic [7:0]       mem_wdata_q;

  logic [CNT_W-1:0] cnt_d;
  logic             timeout_d;
  logic             xact_done_d;

  // The counter value after this cycle's increment is what gets compared,
  // so FAULT is entered after exactly TIMEOUT waiting cycles.
  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_d   = (cnt_d == TIMEOUT_C);
  // A transaction is finished only once busy has been observed high.
  assign xact_done_d = seen_busy_q & ~mem_busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_INIT;
      cnt_q          <= '0;
      seen_busy_q    <= 1'b0;
      addr_q         <= '0;
      we_q           <= 1'b0;
      word_q         <= 1'b0;
      wdata_q        <= '0;
      rlo_q          <= '0;
      cpu_ack_q      <= 1'b0;
      cpu_rdata_q    <= '0;
      cpu_err_q      <= 1'b0;
      ready_q        <= 1'b0;
      mem_addr_q     <= '0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_wdata_q    <= '0;
    end else begin
      cpu_ack_q      <= 1'b0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          if (!mem_busy) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else if (timeout_d) begin
            state_q   <= S_FAULT;
            cpu_err_q <= 1'b1;
            ready_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_IDLE: begin
          if (cpu_req) begin
            addr_q         <= cpu_addr;
            we_q           <= cpu_we;
            word_q         <= cpu_word;
            wdata_q        <= cpu_wdata;
            mem_addr_q     <= cpu_addr;
            mem_wdata_q    <= cpu_wdata[7:0];
            mem_read_en_q  <= ~cpu_we;
            mem_write_en_q <= cpu_we;
            ready_q        <= 1'b0;
            state_q        <= S_ISSUE_LO;
          end
        end
        S_ISSUE_LO: begin
          seen_busy_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (mem_busy) seen_busy_q <= 1'b1;
          if (xact_done_d) begin
            rlo_q <= mem_rdata;
            if (word_q) begin
              mem_addr_q     <= addr_q + 16'd1;
              mem_wdata_q    <= wdata_q[15:8];
              mem_read_en_q  <= ~we_q;
              mem_write_en_q <= we_q;
              state_q        <= S_ISSUE_HI;
            end else begin
              cpu_ack_q <= 1'b1;
              if (!we_q) cpu_rdata_q <= {8'h00, mem_rdata};
              state_q   <= S_DONE;
            end
          end else if (timeout_d) begin
            state_q   <= S_FAULT;
            cpu_err_q <= 1'b1;
            ready_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_ISSUE_HI: begin
          seen_busy_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (mem_busy) seen_busy_q <= 1'b1;
          if (xact_done_d) begin
            cpu_ack_q <= 1'b1;
            if (!we_q) cpu_rdata_q <= {mem_rdata, rlo_q};
            state_q   <= S_DONE;
          end else if (timeout_d) begin
            state_q   <= S_FAULT;
            cpu_err_q <= 1'b1;
            ready_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_FAULT: begin
          cpu_err_q <= 1'b1;
          ready_q   <= 1'b0;
        end
        default: begin
          state_q   <= S_FAULT;
          cpu_err_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack      = cpu_ack_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_err      = cpu_err_q;
  assign ready        = ready_q;
  assign mem_addr     = mem_addr_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_memc_req.sv
// Directed bench for memc_req: a default-timeout instance driven by a small
// controller responder, and a TIMEOUT=8 instance whose controller never
// raises busy.
module tb_memc_req;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cpu_req, cpu_we, cpu_word;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_err, ready;
  logic [15:0] cpu_rdata, mem_addr;
  logic        mem_read_en, mem_write_en, mem_busy;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        reset2, req2;
  logic        ack2, err2, ready2, rd_en2, wr_en2;
  logic [15:0] rdata2, maddr2;
  logic [7:0]  mwdata2;
  logic        busy2 = 1'b0;
  logic [7:0]  mrdata2 = 8'h00;

  memc_req u_dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_word(cpu_word), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .ready(ready),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_rdata(mem_rdata)
  );

  memc_req #(.TIMEOUT(8), .CNT_W(16)) u_dut_t8 (
    .clk(clk), .reset(reset2), .cpu_req(req2), .cpu_we(cpu_we),
    .cpu_word(cpu_word), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(ack2), .cpu_rdata(rdata2), .cpu_err(err2), .ready(ready2),
    .mem_addr(maddr2), .mem_read_en(rd_en2), .mem_write_en(wr_en2),
    .mem_wdata(mwdata2), .mem_busy(busy2), .mem_rdata(mrdata2)
  );

  // Controller responder: busy for busy_len cycles starting the cycle after
  // a command; read data follows the last commanded address.
  logic [7:0]  mem [0:65535];
  logic        busy_force;
  int          busy_len;
  int          busy_cnt = 0;
  logic [15:0] rd_addr_q = 16'h0000;
  logic [15:0] log_addr [32];
  logic [7:0]  log_data [32];
  logic        log_we   [32];
  int          cmd_n = 0, viol = 0, ack_n = 0, cmd2_n = 0, ack2_n = 0;

  assign mem_busy  = busy_force | (busy_cnt != 0);
  assign mem_rdata = mem[rd_addr_q];

  always @(posedge clk) begin
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (cpu_ack) ack_n <= ack_n + 1;
    if (ack2) ack2_n <= ack2_n + 1;
    if (rd_en2 | wr_en2) cmd2_n <= cmd2_n + 1;
    if (mem_read_en | mem_write_en) begin
      if (mem_busy || (mem_read_en && mem_write_en)) viol <= viol + 1;
      if (cmd_n < 32) begin
        log_addr[cmd_n] <= mem_addr;
        log_data[cmd_n] <= mem_wdata;
        log_we[cmd_n]   <= mem_write_en;
      end
      cmd_n     <= cmd_n + 1;
      busy_cnt  <= busy_len;
      rd_addr_q <= mem_addr;
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc, base, ack_snap;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step(1);
      if (cpu_ack) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ack"},   32'(cpu_ack), 32'h0);
    check({tag, "_rdata"}, 32'(cpu_rdata), 32'h0);
    check({tag, "_err"},   32'(cpu_err), 32'h0);
    check({tag, "_ready"}, 32'(ready), 32'h0);
    check({tag, "_maddr"}, 32'(mem_addr), 32'h0);
    check({tag, "_rden"},  32'(mem_read_en), 32'h0);
    check({tag, "_wren"},  32'(mem_write_en), 32'h0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
  endtask

  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_word = 1'b0;
    cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    busy_force = 1'b1; busy_len = 1;
    reset2 = 1'b0; req2 = 1'b0;
    mem[16'h1234] = 8'hA5;
    mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12;
    mem[16'h0300] = 8'h77;
    mem[16'h0301] = 8'h88;
    mem[16'h0042] = 8'h5C;

    step(3);
    check_reset_outs("rst");

    // Controller self-test: busy high for 20 cycles after reset release.
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("init_ready_low", 32'(ready), 32'h0);
    end
    busy_force = 1'b0;
    step(1);
    check("init_ready_high", 32'(ready), 32'h1);
    check("init_no_cmds", 32'(cmd_n), 32'h0);

    // Byte read 1234, busy 2 cycles.
    busy_len = 2; base = cmd_n;
    cpu_we = 1'b0; cpu_word = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
    wait_ack(30, cyc);
    cpu_req = 1'b0;
    check("br_latency", 32'(cyc), 32'd5);
    check("br_rdata", 32'(cpu_rdata), 32'h00A5);
    check("br_ncmd", 32'(cmd_n - base), 32'd1);
    check("br_addr", 32'(log_addr[base]), 32'h1234);
    check("br_is_read", 32'(log_we[base]), 32'h0);
    step(1);
    check("br_ack_pulse", 32'(cpu_ack), 32'h0);
    check("br_ready_back", 32'(ready), 32'h1);

    // Word read at FFFF wraps to 0000.
    busy_len = 1; base = cmd_n;
    cpu_word = 1'b1; cpu_addr = 16'hFFFF; cpu_req = 1'b1;
    wait_ack(30, cyc);
    cpu_req = 1'b0;
    check("wr_latency", 32'(cyc), 32'd7);
    check("wr_rdata", 32'(cpu_rdata), 32'h1234);
    check("wr_ncmd", 32'(cmd_n - base), 32'd2);
    check("wr_addr_lo", 32'(log_addr[base]), 32'hFFFF);
    check("wr_addr_hi", 32'(log_addr[base + 1]), 32'h0000);
    step(1);

    // Word write 0200 <- BEEF, busy 3; fields and req changed after latching.
    busy_len = 3; base = cmd_n; ack_snap = ack_n;
    cpu_we = 1'b1; cpu_word = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 16'hBEEF;
    cpu_req = 1'b1;
    step(1);
    cpu_req = 1'b0; cpu_addr = 16'h5555; cpu_wdata = 16'h1111; cpu_we = 1'b0;
    wait_ack(40, cyc);
    check("ww_latency", 32'(cyc), 32'd10);
    check("ww_rdata_kept", 32'(cpu_rdata), 32'h1234);
    check("ww_ncmd", 32'(cmd_n - base), 32'd2);
    check("ww_cmd0", {15'h0, log_we[base], log_addr[base]}, {15'h0, 1'b1, 16'h0200});
    check("ww_data0", 32'(log_data[base]), 32'hEF);
    check("ww_cmd1", {15'h0, log_we[base + 1], log_addr[base + 1]}, {15'h0, 1'b1, 16'h0201});
    check("ww_data1", 32'(log_data[base + 1]), 32'hBE);
    step(1);
    check("ww_one_ack", 32'(ack_n - ack_snap), 32'd1);
    check("proto_viol", 32'(viol), 32'd0);

    // Reset during WAIT_HI of a word read (busy 4 cycles per byte).
    busy_len = 4; base = cmd_n; ack_snap = ack_n;
    cpu_we = 1'b0; cpu_word = 1'b1; cpu_addr = 16'h0300; cpu_req = 1'b1;
    step(9);
    cpu_req = 1'b0;
    check("rm_ncmd_before", 32'(cmd_n - base), 32'd2);
    reset = 1'b0;
    step(1);
    check_reset_outs("rm");
    step(1);
    reset = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (ready) begin
        cyc = i;
        break;
      end
    end
    check("rm_reinit_ready", 32'(ready), 32'h1);
    check("rm_no_new_cmds", 32'(cmd_n - base), 32'd2);
    check("rm_no_ack", 32'(ack_n - ack_snap), 32'd0);

    busy_len = 1; base = cmd_n;
    cpu_word = 1'b0; cpu_addr = 16'h0042; cpu_req = 1'b1;
    wait_ack(30, cyc);
    cpu_req = 1'b0;
    check("rm_br_latency", 32'(cyc), 32'd4);
    check("rm_br_rdata", 32'(cpu_rdata), 32'h005C);
    check("rm_br_addr", 32'(log_addr[base]), 32'h0042);
    step(1);

    // TIMEOUT=8 instance: busy never rises.
    cpu_we = 1'b0; cpu_word = 1'b0; cpu_addr = 16'h0010;
    reset2 = 1'b1;
    step(1);
    check("t8_ready", 32'(ready2), 32'h1);
    req2 = 1'b1;
    step(1);
    step(8);
    check("t8_no_err_yet", 32'(err2), 32'h0);
    step(1);
    check("t8_err", 32'(err2), 32'h1);
    check("t8_ready_low", 32'(ready2), 32'h0);
    step(10);
    check("t8_err_sticky", 32'(err2), 32'h1);
    check("t8_no_ack", 32'(ack2_n), 32'd0);
    check("t8_one_cmd", 32'(cmd2_n), 32'd1);
    req2 = 1'b0; reset2 = 1'b0;
    step(1);
    check("t8_err_cleared", 32'(err2), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
